lsu: RTL and testbench

Load/store unit between the CPU execute stage and the unified instruction/data memory, acting as the initiator on the memory's data port. Converts a RISC-V load/store request (funct3, byte address, store data) into word-indexed memory transactions and returns a single-cycle response. The memory's write port writes whole words and ignores byte lanes, so the unit performs read-modify-write for sub-word stores. Accesses that cross a word boundary are optionally split into two word transactions.

---
 rtl/lsu.sv | 214 +++++++++++++++++++++
 tb/tb_lsu.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: RV32I load/store request -> word-indexed memory transactions, with read-modify-write for sub-word stores.
// Latency from accept edge to resp_valid: error 1, load/aligned SW 2, RMW store or crossing load 3, crossing store 5 cycles.
// Backpressure: req_ready is high only in IDLE and only while rst is low; resp_valid is an unstallable 1-cycle pulse.
//
// Ports: clk/rst (sync, active-high); req_* request handshake and fields; resp_* completion;
//        wmem/rmem/mem_addr/store_data/load_data drive the memory data port (word addressed).
// Optional feature: define LSU_MISALIGN_EN to split word-crossing accesses into two word
// transactions; without it crossing accesses complete with resp_err and touch no memory.
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [3:0]  wmem,
  output logic [4:0]  rmem,
  output logic [31:0] mem_addr,
  output logic [31:0] store_data,
  input  logic [31:0] load_data
);

  typedef enum logic [2:0] {IDLE, RD0, WR0, RD1, WR1, RESP} state_t;
  state_t state, state_nxt;

  logic        we_q, err_q, native_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [29:0] word_q;
  logic [31:0] wdata_q, w0_q, hi_word;
  logic        accept, split;
  logic [3:0]  lanes0;
  logic [31:0] st_lo, wr_word0, aligned, ext, load_res;

  function automatic logic [3:0] size_lanes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] m);
    logic [31:0] b;
    for (int i = 0; i < 4; i++) b[8*i +: 8] = {8{m[i]}};
    return b;
  endfunction

  // ---------------- request decode ----------------
  logic [1:0] req_off;
  logic [2:0] req_size;
  logic       req_legal, req_cross, req_err, req_native, req_full_sw;

  assign req_off  = req_addr[1:0];
  assign req_size = (req_funct3[1:0] == 2'b00) ? 3'd1 :
                    (req_funct3[1:0] == 2'b01) ? 3'd2 : 3'd4;
  // funct3 x11 never legal; unsigned variants exist only for LBU/LHU.
  assign req_legal = (req_funct3[1:0] != 2'b11) &&
                     (!req_funct3[2] || (!req_we && req_funct3[1:0] != 2'b10));
  assign req_cross = ({1'b0, req_off} + req_size) > 3'd4;
`ifdef LSU_MISALIGN_EN
  assign req_err = !req_legal;
`else
  assign req_err = !req_legal || req_cross;
`endif
  // Native: the memory itself can select and extend the lanes.
  assign req_native  = (req_funct3[1:0] == 2'b00) ||
                       (req_funct3[1:0] == 2'b01 && !req_off[0]) || (req_off == 2'b00);
  assign req_full_sw = req_we && (req_funct3[1:0] == 2'b10) && (req_off == 2'b00);

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // ---------------- latched request and read data ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      native_q <= 1'b0;
      f3_q     <= 3'b0;
      off_q    <= 2'b0;
      word_q   <= 30'b0;
      wdata_q  <= 32'b0;
      w0_q     <= 32'b0;
    end else begin
      if (accept) begin
        we_q     <= req_we;
        err_q    <= req_err;
        native_q <= req_native;
        f3_q     <= req_funct3;
        off_q    <= req_off;
        word_q   <= req_addr[31:2];
        wdata_q  <= req_wdata;
      end
      if (state == RD0) w0_q <= load_data;
    end
  end

`ifdef LSU_MISALIGN_EN
  logic        cross_q;
  logic [31:0] w1_q, st_hi, wr_word1;
  logic [3:0]  lanes1;
  logic [7:0]  lanes8;
  logic [63:0] st64;

  always_ff @(posedge clk) begin
    if (rst) begin
      cross_q <= 1'b0;
      w1_q    <= 32'b0;
    end else begin
      if (accept)         cross_q <= req_cross;
      if (state == RD1)   w1_q    <= load_data;
    end
  end

  assign split    = cross_q;
  assign hi_word  = w1_q;
  assign lanes8   = {4'b0, size_lanes(f3_q[1:0])} << off_q;
  assign lanes0   = lanes8[3:0];
  assign lanes1   = lanes8[7:4];
  assign st64     = {32'b0, wdata_q} << {off_q, 3'b000};
  assign st_lo    = st64[31:0];
  assign st_hi    = st64[63:32];
  assign wr_word1 = (w1_q & ~lane_bits(lanes1)) | (st_hi & lane_bits(lanes1));
`else
  assign split   = 1'b0;
  assign hi_word = 32'b0;
  assign lanes0  = size_lanes(f3_q[1:0]) << off_q;
  assign st_lo   = wdata_q << {off_q, 3'b000};
`endif

  // Merge store bytes into the word read in RD0; a full SW masks out w0_q entirely.
  assign wr_word0 = (w0_q & ~lane_bits(lanes0)) | (st_lo & lane_bits(lanes0));

  // Non-native loads: little-endian merge of the word pair, then extend here.
  assign aligned = 32'({hi_word, w0_q} >> {off_q, 3'b000});
  always_comb begin
    case (f3_q[1:0])
      2'b00:   ext = {{24{~f3_q[2] & aligned[7]}},  aligned[7:0]};
      2'b01:   ext = {{16{~f3_q[2] & aligned[15]}}, aligned[15:0]};
      default: ext = aligned;
    endcase
  end
  assign load_res = native_q ? w0_q : ext;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    wmem       = 4'b0;
    rmem       = 5'b0;
    mem_addr   = 32'b0;
    store_data = 32'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)          state_nxt = RESP;
          else if (req_full_sw) state_nxt = WR0;
          else                  state_nxt = RD0;
        end
      end
      RD0: begin
        mem_addr = {2'b00, word_q};
        rmem     = (!we_q && native_q) ?
                   {~f3_q[2] & (f3_q[1:0] != 2'b10), lanes0} : 5'b01111;
        if (we_q)       state_nxt = WR0;
        else if (split) state_nxt = RD1;
        else            state_nxt = RESP;
      end
      WR0: begin
        mem_addr   = {2'b00, word_q};
        wmem       = lanes0;
        store_data = wr_word0;
        state_nxt  = split ? RD1 : RESP;
      end
`ifdef LSU_MISALIGN_EN
      RD1: begin
        mem_addr  = {2'b00, word_q + 30'd1};  // wraps at 2^30 words
        rmem      = 5'b01111;
        state_nxt = we_q ? WR1 : RESP;
      end
      WR1: begin
        mem_addr   = {2'b00, word_q + 30'd1};
        wmem       = lanes1;
        store_data = wr_word1;
        state_nxt  = RESP;
      end
`endif
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Reset kills any in-flight access in the same cycle: no write lands at the reset edge.
    if (rst) begin
      wmem       = 4'b0;
      rmem       = 5'b0;
      mem_addr   = 32'b0;
      store_data = 32'b0;
    end
  end

  assign resp_valid = (state == RESP) && !rst;
  assign resp_err   = resp_valid && err_q;
  assign resp_data  = (resp_valid && !err_q && !we_q) ? load_res : 32'b0;

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for lsu with a word-wide memory model on the data port.
// Each request is traced for 8 cycles after its accept edge; checks use hand-computed values.
module tb_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [3:0]  wmem;
  logic [4:0]  rmem;
  logic [31:0] mem_addr;
  logic [31:0] store_data;
  logic [31:0] load_data;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .wmem(wmem), .rmem(rmem), .mem_addr(mem_addr), .store_data(store_data),
    .load_data(load_data)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem [0:63];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = 6'b0;
  logic [31:0] pre_dat = 32'b0;
  logic [31:0] ld_word;

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_dat;
    else for (int i = 0; i < 4; i++)
      if (wmem[i]) mem[mem_addr[5:0]][8*i +: 8] <= store_data[8*i +: 8];
  end

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic s);
    return {{24{s & b[7]}}, b};
  endfunction
  function automatic logic [31:0] ext16(input logic [15:0] h, input logic s);
    return {{16{s & h[15]}}, h};
  endfunction

  always_comb begin
    ld_word   = mem[mem_addr[5:0]];
    load_data = 32'h0;
    case (rmem[3:0])
      4'b0001: load_data = ext8(ld_word[7:0],    rmem[4]);
      4'b0010: load_data = ext8(ld_word[15:8],   rmem[4]);
      4'b0100: load_data = ext8(ld_word[23:16],  rmem[4]);
      4'b1000: load_data = ext8(ld_word[31:24],  rmem[4]);
      4'b0011: load_data = ext16(ld_word[15:0],  rmem[4]);
      4'b1100: load_data = ext16(ld_word[31:16], rmem[4]);
      4'b1111: load_data = ld_word;
      default: load_data = 32'h0;
    endcase
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  logic [4:0]  t_rmem [1:8];
  logic [3:0]  t_wmem [1:8];
  logic [31:0] t_addr [1:8];
  logic [31:0] t_sd   [1:8];
  logic        t_rdy  [1:8];
  int          lat;
  logic [31:0] r_data;
  logic        r_err, any_mem, rdy_after, iss_rdy;

  task automatic put(input int idx, input logic [31:0] d);
    pre_we  = 1'b1;
    pre_idx = idx[5:0];
    pre_dat = d;
    @(negedge clk);
    pre_we  = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accept edge with
  // the request fields scrambled, so latching is exercised on every access.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d; req_valid = 1'b1;
    #1 iss_rdy = req_ready;
    @(negedge clk);
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
  endtask

  // Records 8 cycles; cycle c is sampled c negedges after the accept edge.
  task automatic trace(input int rst_at);
    lat = 0; r_data = 32'b0; r_err = 1'b0; any_mem = 1'b0; rdy_after = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      t_rmem[c] = rmem; t_wmem[c] = wmem; t_addr[c] = mem_addr;
      t_sd[c] = store_data; t_rdy[c] = req_ready;
      any_mem = any_mem | (|rmem) | (|wmem);
      if (resp_valid && lat == 0) begin
        lat = c; r_data = resp_data; r_err = resp_err;
      end
      if (rst_at > 0 && c == rst_at) rst = 1'b1;
      if (rst_at > 0 && c == rst_at + 1) begin
        rst = 1'b0;
        #1 rdy_after = req_ready;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_resp", {31'b0, resp_valid} | {31'b0, resp_err} | resp_data, 0);
    check("rst_mem_port", {23'b0, wmem, rmem} | mem_addr | store_data, 0);
    rst = 1'b0;
    #1 check("ready_after_rst", 32'(req_ready), 1);

    // LW aligned
    put(4, 32'hDEADBEEF);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    trace(0);
    check("lw_accept_rdy", 32'(iss_rdy), 1);
    check("lw_rmem", 32'(t_rmem[1]), 32'h0F);
    check("lw_addr", t_addr[1], 32'h4);
    check("lw_busy_rdy", 32'(t_rdy[1]), 0);
    check("lw_lat", lat, 2);
    check("lw_data", r_data, 32'hDEADBEEF);
    check("lw_err", 32'(r_err), 0);

    // LB / LBU on the top byte
    put(4, 32'h80FF0000);
    issue(1'b0, 3'b000, 32'h13, 32'h0);
    trace(0);
    check("lb_rmem", 32'(t_rmem[1]), 32'h18);
    check("lb_data", r_data, 32'hFFFFFF80);
    issue(1'b0, 3'b100, 32'h13, 32'h0);
    trace(0);
    check("lbu_rmem", 32'(t_rmem[1]), 32'h08);
    check("lbu_data", r_data, 32'h00000080);

    // SB read-modify-write
    put(4, 32'h11223344);
    issue(1'b1, 3'b000, 32'h11, 32'h000000AB);
    trace(0);
    check("sb_rd_rmem", 32'(t_rmem[1]), 32'h0F);
    check("sb_rd_wmem", 32'(t_wmem[1]), 0);
    check("sb_wr_wmem", 32'(t_wmem[2]), 32'h2);
    check("sb_wr_rmem", 32'(t_rmem[2]), 0);
    check("sb_wr_data", t_sd[2], 32'h1122AB44);
    check("sb_lat", lat, 3);
    check("sb_resp_data", r_data, 0);
    check("sb_mem", mem[4], 32'h1122AB44);

    // In-word misaligned LH (unit extends), native LHU (memory extends)
    issue(1'b0, 3'b001, 32'h11, 32'h0);
    trace(0);
    check("lh_mis_rmem", 32'(t_rmem[1]), 32'h0F);
    check("lh_mis_lat", lat, 2);
    check("lh_mis_data", r_data, 32'h000022AB);
    issue(1'b0, 3'b101, 32'h12, 32'h0);
    trace(0);
    check("lhu_rmem", 32'(t_rmem[1]), 32'h0C);
    check("lhu_data", r_data, 32'h00001122);

    // SH upper half, then SW aligned
    issue(1'b1, 3'b001, 32'h12, 32'h12345678);
    trace(0);
    check("sh_wmem", 32'(t_wmem[2]), 32'hC);
    check("sh_mem", mem[4], 32'h5678AB44);
    issue(1'b1, 3'b010, 32'h10, 32'hCAFEF00D);
    trace(0);
    check("sw_wmem", 32'(t_wmem[1]), 32'hF);
    check("sw_rmem", 32'(t_rmem[1]), 0);
    check("sw_data", t_sd[1], 32'hCAFEF00D);
    check("sw_lat", lat, 2);
    check("sw_mem", mem[4], 32'hCAFEF00D);

    // Illegal funct3
    issue(1'b0, 3'b011, 32'h10, 32'h0);
    trace(0);
    check("ill_lat", lat, 1);
    check("ill_err", 32'(r_err), 1);
    check("ill_data", r_data, 0);
    check("ill_nomem", 32'(any_mem), 0);

    // Word-crossing accesses
    put(5, 32'h44332211);
    put(6, 32'h88776655);
    issue(1'b0, 3'b010, 32'h16, 32'h0);
    trace(0);
`ifdef LSU_MISALIGN_EN
    check("xlw_addr0", t_addr[1], 32'h5);
    check("xlw_addr1", t_addr[2], 32'h6);
    check("xlw_lat", lat, 3);
    check("xlw_data", r_data, 32'h66554433);
    issue(1'b1, 3'b010, 32'h17, 32'hAABBCCDD);
    trace(0);
    check("xsw_wmem0", 32'(t_wmem[2]), 32'h8);
    check("xsw_wmem1", 32'(t_wmem[4]), 32'h7);
    check("xsw_addr1", t_addr[4], 32'h6);
    check("xsw_lat", lat, 5);
    check("xsw_mem5", mem[5], 32'hDD332211);
    check("xsw_mem6", mem[6], 32'h88AABBCC);

    // Wrap from word 0x3FFFFFFF to word 0
    put(63, 32'h44332211);
    put(0, 32'h88776655);
    issue(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0);
    trace(0);
    check("wrap_addr0", t_addr[1], 32'h3FFFFFFF);
    check("wrap_addr1", t_addr[2], 32'h0);
    check("wrap_data", r_data, 32'h66554433);

    // Reset during WR1: first word committed, second untouched, no response
    put(5, 32'h44332211);
    put(6, 32'h88776655);
    issue(1'b1, 3'b010, 32'h17, 32'hAABBCCDD);
    trace(4);
    check("xrst_lat", lat, 0);
    check("xrst_mem5", mem[5], 32'hDD332211);
    check("xrst_mem6", mem[6], 32'h88776655);
    check("xrst_rdy", 32'(rdy_after), 1);
`else
    check("xlw_err", 32'(r_err), 1);
    check("xlw_lat", lat, 1);
    check("xlw_nomem", 32'(any_mem), 0);
    issue(1'b1, 3'b010, 32'h17, 32'hAABBCCDD);
    trace(0);
    check("xsw_err", 32'(r_err), 1);
    check("xsw_nomem", 32'(any_mem), 0);
    check("xsw_mem5", mem[5], 32'h44332211);

    // Reset during WR0 of a sub-word store: no write, no response
    put(4, 32'h11223344);
    issue(1'b1, 3'b000, 32'h11, 32'h000000AB);
    trace(2);
    check("rst_wr_lat", lat, 0);
    check("rst_wr_mem", mem[4], 32'h11223344);
    check("rst_wr_rdy", 32'(rdy_after), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
